// File: rtl/gate_resp_checker_pkg.sv
// Shared types and constants for the gate block self-checker: FSM encoding,
// response bit positions and the reference and/or/not function.
package gate_resp_checker_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StApply  = 2'd1,
    StSample = 2'd2,
    StDone   = 2'd3
  } state_e;

  localparam int unsigned RESP_W = 3;
  localparam int unsigned O1_BIT = 0;
  localparam int unsigned O2_BIT = 1;
  localparam int unsigned O3_BIT = 2;

  function automatic logic [RESP_W-1:0] gate_model(logic a, logic b);
    logic [RESP_W-1:0] r;
    r         = '0;
    r[O1_BIT] = a & b;
    r[O2_BIT] = a | b;
    r[O3_BIT] = ~a;
    return r;
  endfunction

endpackage

// File: rtl/gate_golden.sv
// Combinational expected-output model of the gate block: {A,B} -> {O3,O2,O1}.
module gate_golden
  import gate_resp_checker_pkg::*;
(
  input  logic              a,
  input  logic              b,
  output logic [RESP_W-1:0] resp
);

  always_comb begin
    resp = gate_model(a, b);
  end

endmodule

// File: rtl/gate_resp_checker.sv
// On-chip BIST for the and/or/not gate block: walks the {A,B} vectors, compares the
// sampled responses against the golden model and keeps error statistics.
module gate_resp_checker
  import gate_resp_checker_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = 4,
  parameter int unsigned SETTLE_CYC  = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             stim_a,
  output logic             stim_b,
  input  logic             resp_o1,
  input  logic             resp_o2,
  input  logic             resp_o3,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       first_err_vec,
  output logic [2:0]       err_mask
);

  // Index is sized from the vector count so long runs work with a narrow error counter.
  localparam int unsigned IDX_W = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
  localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_VECTORS - 1);
  localparam logic [SET_W-1:0] LastSet = SET_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  state_e            state_q, state_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [1:0]        stim_q, stim_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [1:0]        first_q, first_d;
  logic [2:0]        mask_q, mask_d;
  logic              start_q;
  logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [RESP_W-1:0] exp_resp, diff;
  logic              launch;

  gate_golden u_golden (
    .a    (stim_q[1]),
    .b    (stim_q[0]),
    .resp (exp_resp)
  );

  assign diff = {resp_o3, resp_o2, resp_o1} ^ exp_resp;

  // In DONE a start level carried over from the run must drop before it can restart.
  assign launch = start & ((state_q == StIdle) | ((state_q == StDone) & ~start_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (launch) state_d = StApply;
      StApply:  if (settle_q == LastSet) state_d = StSample;
      StSample: state_d = (idx_q == LastIdx) ? StDone : StApply;
      StDone:   if (launch) state_d = StApply;
      default:  state_d = StIdle;
    endcase
  end

  // Status flags trail the state by one register stage so they are glitch-free.
  always_comb begin
    busy_d = (state_q == StApply) | (state_q == StSample);
    done_d = (state_q == StDone);
    pass_d = (state_q == StDone) & (err_cnt_q == '0);
  end

  always_comb begin
    settle_d  = settle_q;
    idx_d     = idx_q;
    stim_d    = stim_q;
    err_cnt_d = err_cnt_q;
    first_d   = first_q;
    mask_d    = mask_q;
    if (launch) begin
      settle_d  = '0;
      idx_d     = '0;
      stim_d    = 2'b00;
      err_cnt_d = '0;
      first_d   = 2'b00;
      mask_d    = 3'b000;
    end else if (state_q == StApply) begin
      settle_d = (settle_q == LastSet) ? '0 : settle_q + SET_W'(1);
    end else if (state_q == StSample) begin
      if (diff != '0) begin
        err_cnt_d = (err_cnt_q == CntMax) ? err_cnt_q : err_cnt_q + CNT_W'(1);
        mask_d    = mask_q | diff;
        if (mask_q == 3'b000) first_d = stim_q;
      end
      if (idx_q != LastIdx) begin
        idx_d  = idx_q + IDX_W'(1);
        stim_d = stim_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_q  <= '0;
      idx_q     <= '0;
      stim_q    <= 2'b00;
      err_cnt_q <= '0;
      first_q   <= 2'b00;
      mask_q    <= 3'b000;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      settle_q  <= settle_d;
      idx_q     <= idx_d;
      stim_q    <= stim_d;
      err_cnt_q <= err_cnt_d;
      first_q   <= first_d;
      mask_q    <= mask_d;
      start_q   <= start;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  assign stim_a        = stim_q[1];
  assign stim_b        = stim_q[0];
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_vec = first_q;
  assign err_mask      = mask_q;

endmodule

// File: tb/tb_gate_resp_checker.sv
// Randomized self-checking bench: two checker instances (default and long saturating run)
// each watching a fault-injectable gate block, compared against a per-run vector model.
module tb_gate_resp_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Fault config per output bit (2 bits each, O1 lowest): 0 ok, 1 stuck0, 2 stuck1, 3 inverted.
  // Bit 6 wires O3 to B.
  logic [6:0] cfg1 = '0, cfg2 = '0;
  logic start1 = 1'b0, start2 = 1'b0;

  logic sa1, sb1, o1_1, o2_1, o3_1, busy1, done1, pass1;
  logic [7:0] cnt1;
  logic [1:0] first1;
  logic [2:0] mask1;
  logic sa2, sb2, o1_2, o2_2, o3_2, busy2, done2, pass2;
  logic [3:0] cnt2;
  logic [1:0] first2;
  logic [2:0] mask2;

  int n_cmp = 0;
  int n_bad = 0;
  int cur_sel = 0;

  function automatic logic [2:0] gate_resp(logic a, logic b, logic [6:0] c);
    logic [2:0] ideal, r;
    ideal = {~a, a | b, a & b};
    for (int i = 0; i < 3; i++) begin
      case (c[2*i+:2])
        2'd0:    r[i] = ideal[i];
        2'd1:    r[i] = 1'b0;
        2'd2:    r[i] = 1'b1;
        default: r[i] = ~ideal[i];
      endcase
    end
    if (c[6]) r[2] = b;
    return r;
  endfunction

  assign {o3_1, o2_1, o1_1} = gate_resp(sa1, sb1, cfg1);
  assign {o3_2, o2_2, o1_2} = gate_resp(sa2, sb2, cfg2);

  gate_resp_checker u_dut (
    .clk (clk), .rst (rst), .start (start1), .stim_a (sa1), .stim_b (sb1),
    .resp_o1 (o1_1), .resp_o2 (o2_1), .resp_o3 (o3_1), .busy (busy1), .done (done1),
    .pass (pass1), .err_cnt (cnt1), .first_err_vec (first1), .err_mask (mask1)
  );

  gate_resp_checker #(.NUM_VECTORS(40), .SETTLE_CYC(2), .CNT_W(4)) u_dut_sat (
    .clk (clk), .rst (rst), .start (start2), .stim_a (sa2), .stim_b (sb2),
    .resp_o1 (o1_2), .resp_o2 (o2_2), .resp_o3 (o3_2), .busy (busy2), .done (done2),
    .pass (pass2), .err_cnt (cnt2), .first_err_vec (first2), .err_mask (mask2)
  );

  logic       obs_done, obs_busy, obs_pass;
  logic [7:0] obs_cnt;
  logic [1:0] obs_first, obs_stim;
  logic [2:0] obs_mask;
  assign obs_done  = cur_sel ? done2 : done1;
  assign obs_busy  = cur_sel ? busy2 : busy1;
  assign obs_pass  = cur_sel ? pass2 : pass1;
  assign obs_cnt   = cur_sel ? {4'd0, cnt2} : cnt1;
  assign obs_first = cur_sel ? first2 : first1;
  assign obs_mask  = cur_sel ? mask2 : mask1;
  assign obs_stim  = cur_sel ? {sa2, sb2} : {sa1, sb1};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_start(input logic v);
    if (cur_sel != 0) start2 = v;
    else              start1 = v;
  endtask

  // Whole-run outcome from the per-vector rules: {A,B} = v mod 4, errors per vector.
  task automatic model_run(input logic [6:0] c, input int nv, input int w,
                           output int cnt, output logic [1:0] first,
                           output logic [2:0] mask);
    int errs;
    logic [1:0] ab;
    logic [2:0] d;
    errs  = 0;
    first = 2'b00;
    mask  = 3'b000;
    for (int v = 0; v < nv; v++) begin
      ab = 2'(v % 4);
      d  = gate_resp(ab[1], ab[0], c) ^ {~ab[1], ab[1] | ab[0], ab[1] & ab[0]};
      if (d != 3'b000) begin
        if (errs == 0) first = ab;
        errs++;
        mask = mask | d;
      end
    end
    cnt = (errs > (1 << w) - 1) ? (1 << w) - 1 : errs;
  endtask

  task automatic run_one(input int sel, input logic [6:0] c, input int nv, input int w,
                         input bit spur, input string tag);
    int cnt, cyc;
    logic [1:0] first, last_ab;
    logic [2:0] mask;
    bit got;
    cur_sel = sel;
    if (sel != 0) cfg2 = c;
    else          cfg1 = c;
    model_run(c, nv, w, cnt, first, mask);
    last_ab = 2'((nv - 1) % 4);
    @(negedge clk);
    set_start(1'b1);
    @(posedge clk);
    #1;
    set_start(1'b0);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < nv * 3 + 20) begin
      @(posedge clk);
      #1;
      cyc++;
      set_start(spur && (cyc == 3 || cyc == 7));
      if (cyc == 5) check_val({tag, ".busy_mid"}, 32'(obs_busy), 32'd1);
      got = obs_done;
    end
    set_start(1'b0);
    check_val({tag, ".latency"}, cyc, nv * 3 + 1);
    check_val({tag, ".busy_done"}, 32'(obs_busy), 32'd0);
    check_val({tag, ".pass"}, 32'(obs_pass), 32'(cnt == 0));
    check_val({tag, ".err_cnt"}, 32'(obs_cnt), cnt);
    check_val({tag, ".first"}, 32'(obs_first), 32'(first));
    check_val({tag, ".mask"}, 32'(obs_mask), 32'(mask));
    check_val({tag, ".stim_last"}, 32'(obs_stim), 32'(last_ab));
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, ".dut"}, {busy1, done1, pass1, cnt1, first1, mask1, sa1, sb1}, 32'd0);
    check_val({tag, ".sat"}, {busy2, done2, pass2, cnt2, first2, mask2, sa2, sb2}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("idle");

    run_one(0, 7'h00, 4, 8, 1'b0, "clean");
    run_one(0, 7'h01, 4, 8, 1'b0, "o1_stuck0");
    run_one(0, 7'h40, 4, 8, 1'b1, "o3_eq_b");
    for (int i = 0; i < 6; i++) begin
      run_one(0, 7'($urandom), 4, 8, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    // Start raised late in the run and held into DONE must not restart.
    cur_sel = 0;
    cfg1 = 7'h04;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    start1 = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_val("held_start.done", 32'(done1), 32'd1);
    check_val("held_start.busy", 32'(busy1), 32'd0);
    check_val("held_start.cnt", 32'(cnt1), 32'd3);
    start1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("held_start.still_done", 32'(done1), 32'd1);
    run_one(0, 7'h00, 4, 8, 1'b0, "restart");

    // Reset in the middle of a run.
    cfg1 = 7'h03;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    run_one(0, 7'h00, 4, 8, 1'b0, "after_reset");

    run_one(1, 7'h04, 40, 4, 1'b0, "sat_o2");
    for (int i = 0; i < 2; i++) begin
      run_one(1, 7'($urandom), 40, 4, 1'b1, $sformatf("sat_rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
